// File: rtl/mem_arbiter_if.sv
// Request, response and memory-port bundle for mem_arbiter.
// slave: the arbiter side. master: requesters plus the memory device.
interface mem_arbiter_if #(
  parameter int MEMSIZE  = 64,
  parameter int WORDSIZE = 64
);
  logic                req0_valid;
  logic                req0_we;
  logic [MEMSIZE-1:0]  req0_addr;
  logic [WORDSIZE-1:0] req0_wdata;
  logic                req0_ready;
  logic                req1_valid;
  logic                req1_we;
  logic [MEMSIZE-1:0]  req1_addr;
  logic [WORDSIZE-1:0] req1_wdata;
  logic                req1_ready;
  logic                rsp0_valid;
  logic                rsp1_valid;
  logic [WORDSIZE-1:0] rsp_rdata;
  logic                mem_wren;
  logic                mem_rden;
  logic [MEMSIZE-1:0]  mem_addr;
  logic [WORDSIZE-1:0] mem_d;
  logic [WORDSIZE-1:0] mem_q;
  logic                busy;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_q,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    output mem_wren, mem_rden, mem_addr, mem_d, busy
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_q,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    input  mem_wren, mem_rden, mem_addr, mem_d, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: fixed 3-cycle accept/strobe/response.
// Define MEM_ARBITER_RR_EN for round-robin tie-break; default gives requester 1 priority.
module mem_arbiter #(
  parameter int MEMSIZE  = 64,
  parameter int WORDSIZE = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                winner;
  logic                we_q;
  logic                id_q;
  logic [MEMSIZE-1:0]  addr_q;
  logic [WORDSIZE-1:0] wdata_q;
  logic [WORDSIZE-1:0] rdata_q;

`ifdef MEM_ARBITER_RR_EN
  // Requester that wins the next tie; flips to the other one on every accept.
  logic prio_q;

  always_comb begin
    winner = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) winner = prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prio_q <= 1'b0;
    else if (accept) prio_q <= ~winner;
  end
`else
  always_comb begin
    winner = bus.req1_valid;
  end
`endif

  // rst_n gates accept so ready stays low while reset is held.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q    <= winner;
        we_q    <= winner ? bus.req1_we    : bus.req0_we;
        addr_q  <= winner ? bus.req1_addr  : bus.req0_addr;
        wdata_q <= winner ? bus.req1_wdata : bus.req0_wdata;
      end
      if (state == ACCESS && !we_q) rdata_q <= bus.mem_q;
    end
  end

  assign bus.req0_ready = accept && !winner;
  assign bus.req1_ready = accept && winner;
  assign bus.mem_wren   = (state == ACCESS) && we_q;
  assign bus.mem_rden   = (state == ACCESS) && !we_q;
  assign bus.rsp0_valid = (state == RESP) && !id_q;
  assign bus.rsp1_valid = (state == RESP) && id_q;
  assign bus.busy       = (state != IDLE);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_d      = wdata_q;
  assign bus.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-timing reference model (grant cycle g -> strobe g+1, response g+2).
module tb_mem_arbiter;
  localparam int MEMSIZE  = 64;
  localparam int WORDSIZE = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.MEMSIZE(MEMSIZE), .WORDSIZE(WORDSIZE)) bus ();
  mem_arbiter #(.MEMSIZE(MEMSIZE), .WORDSIZE(WORDSIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory device: 16 words aliased on addr[3:0], combinational read.
  function automatic logic [63:0] init_val(input logic [3:0] a);
    return (a == 4'd5) ? 64'hAA : ({16{a}} ^ 64'h0123_4567_89AB_CDEF);
  endfunction

  logic [63:0] mem [16];
  logic [15:0] written = '0;
  always @(posedge clk) begin
    if (bus.mem_wren) begin
      mem[bus.mem_addr[3:0]]     <= bus.mem_d;
      written[bus.mem_addr[3:0]] <= 1'b1;
    end
  end
  assign bus.mem_q = written[bus.mem_addr[3:0]] ? mem[bus.mem_addr[3:0]]
                                                : init_val(bus.mem_addr[3:0]);

  typedef struct packed {
    logic r0, r1, s0, s1, wr, rd, busy;
    logic [63:0] rdata, addr, d;
  } obs_t;

  function automatic obs_t sample_dut();
    obs_t o;
    o.r0 = bus.req0_ready;  o.r1 = bus.req1_ready;
    o.s0 = bus.rsp0_valid;  o.s1 = bus.rsp1_valid;
    o.wr = bus.mem_wren;    o.rd = bus.mem_rden;   o.busy = bus.busy;
    o.rdata = bus.rsp_rdata; o.addr = bus.mem_addr; o.d = bus.mem_d;
    return o;
  endfunction

  // Reference model state
  int          ref_g = -10;
  logic        ref_we, ref_id, ref_last;
  logic [63:0] ref_addr, ref_wdata, ref_rdata;
  logic [63:0] ref_mem [16];
  logic [15:0] ref_written = '0;

  function automatic logic ref_winner();
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef MEM_ARBITER_RR_EN
      return !ref_last;
`else
      return 1'b1;
`endif
    end
    return bus.req1_valid;
  endfunction

  function automatic obs_t model_eval();
    obs_t e;
    logic idle, any, w;
    e = '0;
    if (!rst_n) return e;
    idle = !(cyc == ref_g + 1 || cyc == ref_g + 2);
    any  = bus.req0_valid | bus.req1_valid;
    w    = ref_winner();
    e.r0 = idle && any && !w;
    e.r1 = idle && any && w;
    e.wr = (cyc == ref_g + 1) && ref_we;
    e.rd = (cyc == ref_g + 1) && !ref_we;
    e.s0 = (cyc == ref_g + 2) && !ref_id;
    e.s1 = (cyc == ref_g + 2) && ref_id;
    e.busy  = !idle;
    e.rdata = ref_rdata;
    e.addr  = ref_addr;
    e.d     = ref_wdata;
    return e;
  endfunction

  function automatic void model_commit(input obs_t e);
    int a;
    if (!rst_n) begin
      ref_g = -10; ref_we = 1'b0; ref_id = 1'b0; ref_last = 1'b1;
      ref_addr = '0; ref_wdata = '0; ref_rdata = '0;
      return;
    end
    if (cyc == ref_g + 1) begin
      a = int'(ref_addr[3:0]);
      if (ref_we) begin
        ref_mem[a] = ref_wdata;
        ref_written[a] = 1'b1;
      end else begin
        ref_rdata = ref_written[a] ? ref_mem[a] : init_val(ref_addr[3:0]);
      end
    end
    if (e.r0 || e.r1) begin
      ref_g = cyc; ref_id = e.r1; ref_last = e.r1;
      ref_we    = e.r1 ? bus.req1_we    : bus.req0_we;
      ref_addr  = e.r1 ? bus.req1_addr  : bus.req0_addr;
      ref_wdata = e.r1 ? bus.req1_wdata : bus.req0_wdata;
    end
  endfunction

  task automatic clear_reqs();
    bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
  endtask

  task automatic test_reset();
    obs_t e, o;
    clear_reqs();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_model cyc=%0d obs=%h exp=%h", cyc, o, e); end
      vectors++;
      if (o !== '0) begin miscompares++; $display("FAIL reset_zero obs=%h exp=0", o); end
      model_commit(e);
      @(posedge clk); #1;
    end
    clear_reqs();
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    obs_t e, o;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 64'd5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL read cyc=%0d obs=%h exp=%h", cyc, o, e); end
      vectors++;
      if (k == 0 && {o.r0, o.r1} !== 2'b10) begin
        miscompares++; $display("FAIL read_ready obs=%b exp=10", {o.r0, o.r1});
      end else if (k == 1 && {o.rd, o.wr, o.addr} !== {2'b10, 64'd5}) begin
        miscompares++; $display("FAIL read_strobe obs=%b%b addr=%h exp=10 addr=5", o.rd, o.wr, o.addr);
      end else if (k == 2 && {o.s0, o.s1, o.rdata} !== {2'b10, 64'hAA}) begin
        miscompares++; $display("FAIL read_rsp obs=%b%b rdata=%h exp=10 rdata=aa", o.s0, o.s1, o.rdata);
      end
      model_commit(e);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
    end
  endtask

  task automatic test_write();
    obs_t e, o;
    bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 64'd3; bus.req1_wdata = 64'h1234;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL write cyc=%0d obs=%h exp=%h", cyc, o, e); end
      vectors++;
      if (k == 1 && {o.wr, o.rd, o.d, o.addr} !== {2'b10, 64'h1234, 64'd3}) begin
        miscompares++; $display("FAIL write_strobe obs=%b%b d=%h exp=10 d=1234", o.wr, o.rd, o.d);
      end else if (k == 2 && {o.s1, o.s0, o.rdata} !== {2'b10, 64'hAA}) begin
        miscompares++; $display("FAIL write_ack obs=%b%b rdata=%h exp=10 rdata=aa", o.s1, o.s0, o.rdata);
      end
      model_commit(e);
      @(posedge clk); #1;
      bus.req1_valid = 1'b0;
    end
  endtask

  task automatic test_contention();
    obs_t e, o;
    int   ng;
    logic got [5];
    logic exp_id;
    clear_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    e = model_eval(); model_commit(e);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_addr = 64'd7;
    bus.req1_valid = 1'b1; bus.req1_addr = 64'd9;
    ng = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL contention cyc=%0d obs=%h exp=%h", cyc, o, e); end
      if ((o.r0 || o.r1) && ng < 5) begin got[ng] = o.r1; ng++; end
      model_commit(e);
      @(posedge clk); #1;
      if (e.r0) bus.req0_addr = 64'($urandom_range(0, 15));
      if (e.r1) bus.req1_addr = 64'($urandom_range(0, 15));
    end
    vectors++;
    if (ng != 5) begin miscompares++; $display("FAIL contention_count obs=%0d exp=5", ng); end
    for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b1;
`endif
      vectors++;
      if (got[i] !== exp_id) begin
        miscompares++; $display("FAIL contention_grant%0d obs=%b exp=%b", i, got[i], exp_id);
      end
    end
    clear_reqs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL contention_drain cyc=%0d obs=%h exp=%h", cyc, o, e); end
      model_commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midop();
    obs_t e, o;
    bus.req0_valid = 1'b1; bus.req0_we = 1'b1; bus.req0_addr = 64'd11; bus.req0_wdata = 64'hDEAD_BEEF;
    @(negedge clk);
    e = model_eval(); o = sample_dut(); vectors++;
    if (o !== e) begin miscompares++; $display("FAIL midop_accept cyc=%0d obs=%h exp=%h", cyc, o, e); end
    model_commit(e);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 o = sample_dut(); vectors++;
    if (o !== '0) begin miscompares++; $display("FAIL midop_abort obs=%h exp=0", o); end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL midop cyc=%0d obs=%h exp=%h", cyc, o, e); end
      vectors++;
      if ({o.s0, o.s1, o.wr, o.rd} !== 4'b0) begin
        miscompares++; $display("FAIL midop_quiet obs=%b exp=0000", {o.s0, o.s1, o.wr, o.rd});
      end
      model_commit(e);
      @(posedge clk); #1;
      if (k == 1) rst_n = 1'b1;
    end
  endtask

  task automatic test_idle();
    obs_t e, o;
    clear_reqs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL idle cyc=%0d obs=%h exp=%h", cyc, o, e); end
      vectors++;
      if ({o.busy, o.wr, o.rd} !== 3'b0) begin
        miscompares++; $display("FAIL idle_strobes obs=%b exp=000", {o.busy, o.wr, o.rd});
      end
      model_commit(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    obs_t e, o;
    logic acc0, acc1;
    acc0 = 1'b1; acc1 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_we    = 1'($urandom_range(0, 1));
        bus.req0_addr  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
        bus.req0_wdata = {$urandom, $urandom};
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_we    = 1'($urandom_range(0, 1));
        bus.req1_addr  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 15));
        bus.req1_wdata = {$urandom, $urandom};
      end
      if (i == 200) rst_n = 1'b0;
      if (i == 202) rst_n = 1'b1;
      @(negedge clk);
      e = model_eval(); o = sample_dut(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, o, e); end
      acc0 = e.r0; acc1 = e.r1;
      model_commit(e);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_idle();
    test_reset_midop();
    test_contention();
    test_random();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
